idma_axis_accel_loopback: RTL and testbench
===========================================

Name: idma_axis_accel_loopback

Overview:
- Synthesizable AXI-Stream accelerator stage on the iDMA streaming ports.
- Consumes beats from the iDMA streaming write port (DMA -> accelerator) and buffers them in a FIFO.
- Applies a per-packet data transform and returns the beats on the iDMA streaming read port (accelerator -> DMA).
- Replaces the behavioural queue-based accelerator model in system benches so AXI -> AXI-S -> AXI descriptor chains run in RTL.

Parameters:
- DataWidth, 64, tdata width in bits; must be a multiple of 8.
- KeepWidth, DataWidth/8, tkeep width.
- Depth, 8, FIFO entries; power of two, >= 2.
- CntWidth, 16, width of the packet and beat counters.

Ports:
- clk_i  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- s_tdata_i  in  DataWidth  input beat data (from iDMA streaming write req).
- s_tkeep_i  in  KeepWidth  input byte keep.
- s_tlast_i  in  1  input end of packet.
- s_tvalid_i  in  1  input valid.
- s_tready_o  out  1  input ready (to iDMA streaming write rsp).
- m_tdata_o  out  DataWidth  output beat data (to iDMA streaming read req).
- m_tkeep_o  out  KeepWidth  output byte keep.
- m_tlast_o  out  1  output end of packet.
- m_tvalid_o  out  1  output valid.
- m_tready_i  in  1  output ready (from iDMA streaming read rsp).
- op_i  in  2  transform: 0 pass, 1 add operand, 2 xor operand, 3 byte-reverse.
- operand_i  in  DataWidth  operand for ops 1 and 2.
- pkt_cnt_o  out  CntWidth  packets fully emitted on the m side.
- occupancy_o  out  $clog2(Depth)+1  current FIFO fill level.

Behaviour:
- Reset (rst high, asynchronous): FIFO empty, pointers 0, counters 0, packet state IDLE, stored op 0.
  - Output values during reset: s_tready_o=0, m_tvalid_o=0, m_tdata_o/m_tkeep_o/m_tlast_o=0, pkt_cnt_o=0, occupancy_o=0.
  - s_tready_o rises in the first cycle after rst deasserts.
- Input handshake: a beat is accepted when s_tvalid_i && s_tready_o at the clk_i rising edge.
  - s_tready_o = (occupancy != Depth); it depends only on registered state, never on m_tready_i.
- Packet FSM, two states:
  - IDLE: an accepted beat latches op_i/operand_i into op_q/operand_q.
    - If tlast=0 -> INPKT.
    - If tlast=1 (single-beat packet) -> stay IDLE.
  - INPKT: op_i/operand_i are ignored; beats use op_q/operand_q. An accepted beat with tlast=1 -> IDLE.
  - In IDLE the first beat uses the live op_i/operand_i, same value as latched.
- Transform, applied at enqueue; the FIFO stores transformed data:
  - Op 1: tdata + operand, modulo 2^DataWidth, carry discarded.
  - Op 2: tdata ^ operand.
  - Op 3: byte order reversed; byte i moves to byte KeepWidth-1-i.
  - tkeep and tlast are stored unchanged, except op 3 also reverses tkeep bit order.
- Output: m_tvalid_o = (occupancy != 0). m_tdata_o/m_tkeep_o/m_tlast_o come from the head entry. Head is popped on m_tvalid_o && m_tready_i.
  - AXI-S stability holds: payload stays constant while valid && !ready.
- Latency: a beat accepted at edge N is presented with m_tvalid_o=1 after edge N; minimum 1 cycle, no fall-through.
- Simultaneous push and pop in one cycle: occupancy unchanged. This is allowed at any level 1..Depth-1.
  - At Depth no push is possible (s_tready_o=0); a pop at Depth reopens s_tready_o the next cycle.
  - At 0 no pop is possible.
- Pointers are log2(Depth) bits and wrap naturally.
- pkt_cnt_o increments on each output handshake with m_tlast_o=1 and wraps at 2^CntWidth.
- Reset mid-packet: all buffered beats are discarded, the FSM returns to IDLE, counters clear. No partial packet is emitted after reset.
- Only tkeep==all-ones or a trailing-byte mask on tlast beats is expected. Other masks pass through untransformed-checked; no error is signalled.

Optional Feature:
- Macro IDMA_AXIS_ACCEL_PERF_EN.
- When defined, adds output ports:
  - beat_in_cnt_o (CntWidth): accepted input beats.
  - beat_out_cnt_o (CntWidth): emitted beats.
  - max_occ_o ($clog2(Depth)+1): high-water mark of occupancy.
  - All three wrap (counters) or saturate (max_occ_o) and clear on rst.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Op 0, 16 beats 0x1..0x10 with tlast on the 16th, m_tready_i=1 -> output 0x1..0x10 in order, tlast only on 0x10, pkt_cnt_o=1, first m_tvalid_o one cycle after first accept.
- Op 1, operand 0x100, beats 0x1..0x4; change op_i to 2 after beat 1 -> outputs 0x101,0x102,0x103,0x104 (op latched per packet).
- Op 3, beat 0x0102030405060708, tkeep 0xFF, tlast=1 -> output 0x0807060504030201; pkt_cnt_o increments in IDLE->IDLE case.
- Depth=8, m_tready_i=0, 10 valid beats offered -> exactly 8 accepted, s_tready_o=0, occupancy_o=8; raise m_tready_i for 1 cycle -> s_tready_o=1 next cycle, remaining beats flow, order preserved.
- Occupancy 4, s_tvalid_i=m_tready_i=1 for 20 cycles -> occupancy_o stays 4, 20 beats in and out, no drop or duplication.
- Assert rst after beat 3 of an 8-beat packet -> m_tvalid_o=0 and occupancy_o=0 immediately; after release a new 2-beat packet emerges alone with pkt_cnt_o=1.

Source files
------------

// File: rtl/idma_axis_accel_loopback_if.sv
// AXI-Stream beat bundle shared by the accelerator's input and output sides.
// The master drives the payload and valid; the slave drives ready.
interface idma_axis_accel_loopback_if #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned KeepWidth = DataWidth / 8
);
  logic [DataWidth-1:0] tdata;
  logic [KeepWidth-1:0] tkeep;
  logic                 tlast;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/idma_axis_accel_loopback.sv
// AXI-Stream accelerator stage: per-packet transform at enqueue, FIFO, loop back to the DMA.
// Optional beat/high-water statistics ports are enabled by defining IDMA_AXIS_ACCEL_PERF_EN.
module idma_axis_accel_loopback #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned KeepWidth = DataWidth / 8,
  parameter int unsigned Depth     = 8,
  parameter int unsigned CntWidth  = 16,
  localparam int unsigned PtrWidth = $clog2(Depth),
  localparam int unsigned OccWidth = $clog2(Depth) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst,
  idma_axis_accel_loopback_if.slave  s,
  idma_axis_accel_loopback_if.master m,
  input  logic [1:0]           op_i,
  input  logic [DataWidth-1:0] operand_i,
  output logic [CntWidth-1:0]  pkt_cnt_o,
  output logic [OccWidth-1:0]  occupancy_o
`ifdef IDMA_AXIS_ACCEL_PERF_EN
  ,
  output logic [CntWidth-1:0]  beat_in_cnt_o,
  output logic [CntWidth-1:0]  beat_out_cnt_o,
  output logic [OccWidth-1:0]  max_occ_o
`endif
);

  localparam int unsigned EntryWidth = DataWidth + KeepWidth + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    INPKT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           op_q;
  logic [DataWidth-1:0] operand_q;
  logic [1:0]           op_sel;
  logic [DataWidth-1:0] operand_sel;
  logic                 latch_en;

  logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OccWidth-1:0]   occ_q;
  logic                  rdy_en_q;
  logic [CntWidth-1:0]   pkt_cnt_q;
  logic [EntryWidth-1:0] mem_q [Depth];
  logic [EntryWidth-1:0] head;

  logic                 push, pop;
  logic [DataWidth-1:0] rev_data, xf_data;
  logic [KeepWidth-1:0] rev_keep, xf_keep;

  // Ready is held low until the first edge after reset so nothing is taken during release.
  assign s.tready = rdy_en_q && (occ_q != OccWidth'(Depth));
  assign m.tvalid = (occ_q != '0);
  assign push     = s.tvalid && s.tready;
  assign pop      = m.tvalid && m.tready;

  // Packet state register with the per-packet op latch.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 2'd0;
      operand_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        op_q      <= op_i;
        operand_q <= operand_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (push && !s.tlast) state_d = INPKT;
      INPKT:   if (push && s.tlast)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The first beat of a packet uses the live op, which is the value being latched.
  always_comb begin
    op_sel      = op_q;
    operand_sel = operand_q;
    latch_en    = 1'b0;
    if (state_q == IDLE) begin
      op_sel      = op_i;
      operand_sel = operand_i;
      latch_en    = push;
    end
  end

  for (genvar gi = 0; gi < KeepWidth; gi++) begin : g_rev
    assign rev_data[gi*8 +: 8] = s.tdata[(KeepWidth-1-gi)*8 +: 8];
    assign rev_keep[gi]        = s.tkeep[KeepWidth-1-gi];
  end

  always_comb begin
    xf_data = s.tdata;
    xf_keep = s.tkeep;
    unique case (op_sel)
      2'd1: xf_data = s.tdata + operand_sel;
      2'd2: xf_data = s.tdata ^ operand_sel;
      2'd3: begin
        xf_data = rev_data;
        xf_keep = rev_keep;
      end
      default: ;
    endcase
  end

  // Storage carries no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {s.tlast, xf_keep, xf_data};
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      rdy_en_q  <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      if (push && !pop)      occ_q <= occ_q + OccWidth'(1);
      else if (!push && pop) occ_q <= occ_q - OccWidth'(1);
      if (pop && m.tlast) pkt_cnt_q <= pkt_cnt_q + CntWidth'(1);
    end
  end

  // Payload is forced to zero while empty so reset shows a clean bus.
  assign head    = mem_q[rd_ptr_q];
  assign m.tdata = m.tvalid ? head[DataWidth-1:0] : '0;
  assign m.tkeep = m.tvalid ? head[DataWidth +: KeepWidth] : '0;
  assign m.tlast = m.tvalid ? head[EntryWidth-1] : 1'b0;

  assign pkt_cnt_o   = pkt_cnt_q;
  assign occupancy_o = occ_q;

`ifdef IDMA_AXIS_ACCEL_PERF_EN
  logic [CntWidth-1:0] beat_in_q, beat_out_q;
  logic [OccWidth-1:0] max_occ_q;

  // Occupancy never exceeds Depth, so the high-water mark saturates there.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      beat_in_q  <= '0;
      beat_out_q <= '0;
      max_occ_q  <= '0;
    end else begin
      if (push) beat_in_q  <= beat_in_q + CntWidth'(1);
      if (pop)  beat_out_q <= beat_out_q + CntWidth'(1);
      if (occ_q > max_occ_q) max_occ_q <= occ_q;
    end
  end

  assign beat_in_cnt_o  = beat_in_q;
  assign beat_out_cnt_o = beat_out_q;
  assign max_occ_o      = max_occ_q;
`endif

endmodule

// File: tb/tb_idma_axis_accel_loopback.sv
// Randomized bench for idma_axis_accel_loopback against a packet-level queue model.
module tb_idma_axis_accel_loopback;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int DEPTH = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  idma_axis_accel_loopback_if #(.DataWidth(DW)) s_if ();
  idma_axis_accel_loopback_if #(.DataWidth(DW)) m_if ();

  logic [1:0]    op = 2'd0;
  logic [DW-1:0] opnd = '0;
  logic [CW-1:0] pkt_cnt;
  logic [3:0]    occ;
`ifdef IDMA_AXIS_ACCEL_PERF_EN
  logic [CW-1:0] beat_in_cnt, beat_out_cnt;
  logic [3:0]    max_occ;
`endif

  idma_axis_accel_loopback #(.DataWidth(DW), .Depth(DEPTH), .CntWidth(CW)) dut (
    .clk_i       (clk),
    .rst         (rst),
    .s           (s_if),
    .m           (m_if),
    .op_i        (op),
    .operand_i   (opnd),
    .pkt_cnt_o   (pkt_cnt),
    .occupancy_o (occ)
`ifdef IDMA_AXIS_ACCEL_PERF_EN
    ,
    .beat_in_cnt_o  (beat_in_cnt),
    .beat_out_cnt_o (beat_out_cnt),
    .max_occ_o      (max_occ)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  beat_t         exp_q[$];
  int            exp_pkts = 0;
  bit            in_pkt = 0;
  logic [1:0]    lat_op = 2'd0;
  logic [DW-1:0] lat_opnd = '0;
  int            rdy_pct = 100;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected beat from the transform rules: add mod 2^64, xor, or byte/keep reversal.
  function automatic beat_t model_xf(input logic [1:0] o, input logic [DW-1:0] od,
                                     input logic [DW-1:0] d, input logic [KW-1:0] k,
                                     input logic l);
    beat_t r;
    r.d = d;
    r.k = k;
    r.l = l;
    case (o)
      2'd1: r.d = d + od;
      2'd2: r.d = d ^ od;
      2'd3: for (int i = 0; i < KW; i++) begin
        r.d[8*(KW-1-i) +: 8] = d[8*i +: 8];
        r.k[KW-1-i]          = k[i];
      end
      default: ;
    endcase
    return r;
  endfunction

  // One clock cycle: drive at the falling edge, check outputs, advance the model.
  task automatic step(input bit v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input bit l, input logic [1:0] o, input logic [DW-1:0] od,
                      output bit acc);
    bit rdy;
    rdy = ($urandom_range(99) < rdy_pct);
    @(negedge clk);
    s_if.tvalid = v;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    m_if.tready = rdy;
    op          = o;
    opnd        = od;
    check("s_tready", s_if.tready, exp_q.size() != DEPTH);
    check("m_tvalid", m_if.tvalid, exp_q.size() != 0);
    check("occupancy", occ, exp_q.size());
    check("pkt_cnt", pkt_cnt, exp_pkts);
    acc = v && (exp_q.size() != DEPTH);
    if (exp_q.size() != 0) begin
      check("m_tdata", m_if.tdata, exp_q[0].d);
      check("m_tkeep", m_if.tkeep, exp_q[0].k);
      check("m_tlast", m_if.tlast, exp_q[0].l);
      if (rdy) begin
        $display("out beat data=%h keep=%h last=%b", exp_q[0].d, exp_q[0].k, exp_q[0].l);
        if (exp_q[0].l) exp_pkts = (exp_pkts + 1) % (1 << CW);
        void'(exp_q.pop_front());
      end
    end
    if (acc) begin
      if (!in_pkt) begin
        lat_op   = o;
        lat_opnd = od;
      end
      exp_q.push_back(model_xf(lat_op, lat_opnd, d, k, l));
      in_pkt = !l;
    end
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit l,
                           input logic [1:0] o, input logic [DW-1:0] od);
    bit acc;
    int t;
    t = 0;
    do begin
      step(1'b1, d, k, l, o, od, acc);
      t++;
    end while (!acc && t < 200);
    check("accept_timeout", acc, 1);
  endtask

  task automatic drain();
    bit acc;
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      step(1'b0, '0, '0, 1'b0, 2'd0, '0, acc);
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    #1;
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_occupancy", occ, 0);
    check("rst_s_tready", s_if.tready, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_m_tlast", m_if.tlast, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    exp_q.delete();
    exp_pkts = 0;
    in_pkt   = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_low_at_release", s_if.tready, 0);
  endtask

  initial begin
    bit acc;
    int len;
    logic [1:0]    ro;
    logic [DW-1:0] rod;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    do_reset();

    // Pass-through packet of 16 beats.
    rdy_pct = 100;
    for (int i = 1; i <= 16; i++) push_beat(DW'(i), 8'hFF, i == 16, 2'd0, '0);
    drain();
    step(1'b0, '0, '0, 1'b0, 2'd0, '0, acc);
    check("pkt_cnt_op0", pkt_cnt, 1);

    // Add packet; op input changes after the first beat and must be ignored.
    push_beat(64'h1, 8'hFF, 1'b0, 2'd1, 64'h100);
    for (int i = 2; i <= 4; i++) push_beat(DW'(i), 8'hFF, i == 4, 2'd2, 64'hFFFF);
    drain();

    // Single-beat byte reverse.
    push_beat(64'h0102030405060708, 8'hFF, 1'b1, 2'd3, '0);
    push_beat(64'h1122334455667788, 8'h0F, 1'b1, 2'd3, '0);
    drain();

    // Fill to Depth with the sink stalled, then release one slot.
    rdy_pct = 0;
    for (int i = 0; i < 8; i++) push_beat(64'h20 + DW'(i), 8'hFF, 1'b0, 2'd2, 64'hA5);
    step(1'b1, 64'h28, 8'hFF, 1'b0, 2'd0, '0, acc);
    check("full_no_accept", acc, 0);
    step(1'b1, 64'h28, 8'hFF, 1'b0, 2'd0, '0, acc);
    check("full_occupancy", occ, 8);
    rdy_pct = 100;
    step(1'b0, '0, '0, 1'b0, 2'd0, '0, acc);
    rdy_pct = 0;
    step(1'b1, 64'h28, 8'hFF, 1'b0, 2'd0, '0, acc);
    check("reopen_accept", acc, 1);
    rdy_pct = 100;
    push_beat(64'h29, 8'hFF, 1'b1, 2'd0, '0);
    drain();

    // Steady simultaneous push/pop at occupancy 4.
    rdy_pct = 0;
    for (int i = 0; i < 4; i++) push_beat({$urandom, $urandom}, 8'hFF, 1'b0, 2'd1, 64'h7);
    rdy_pct = 100;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, {$urandom, $urandom}, 8'hFF, i == 19, 2'd0, '0, acc);
      check("steady_accept", acc, 1);
    end
    check("steady_occupancy", occ, 4);
    drain();

    // Reset in the middle of a buffered packet.
    rdy_pct = 0;
    for (int i = 0; i < 3; i++) push_beat(64'h40 + DW'(i), 8'hFF, 1'b0, 2'd0, '0);
    do_reset();
    rdy_pct = 100;
    push_beat(64'h51, 8'hFF, 1'b0, 2'd2, 64'hF0);
    push_beat(64'h52, 8'hFF, 1'b1, 2'd0, '0);
    drain();
    step(1'b0, '0, '0, 1'b0, 2'd0, '0, acc);
    check("pkt_cnt_after_rst", pkt_cnt, 1);

    // Random packets, ops, trailing keep masks, source gaps and sink backpressure.
    rdy_pct = 60;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 8);
      ro  = 2'($urandom_range(3));
      rod = {$urandom, $urandom};
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(3) == 0) step(1'b0, '0, '0, 1'b0, 2'd0, '0, acc);
        push_beat({$urandom, $urandom},
                  (b == len - 1) ? (8'hFF >> $urandom_range(7)) : 8'hFF,
                  b == len - 1,
                  (b == 0) ? ro : 2'($urandom_range(3)),
                  (b == 0) ? rod : {$urandom, $urandom});
      end
    end
    rdy_pct = 100;
    drain();
    step(1'b0, '0, '0, 1'b0, 2'd0, '0, acc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
